// File: rtl/led_status_panel.sv
// Office-status LED panel: packs switches, hour and presence flags onto the LED bar,
// with a debounced up-button alert mode that blinks or blanks the bar.
module led_status_panel #(
  parameter int SW_W            = 9,
  parameter int HOUR_W          = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_DIV       = 25_000_000,
  parameter int ALERT_BLINKS    = 4,
  localparam int LED_W          = SW_W + HOUR_W + 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btnu,
  input  logic              student,
  input  logic              prof,
  input  logic              pm,
  input  logic [HOUR_W-1:0] hour,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led,
  output logic              alert
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BLK_W = $clog2(BLINK_DIV + 1);
  localparam int PER_W = (ALERT_BLINKS == 0) ? 1 : $clog2(ALERT_BLINKS + 1);
  localparam int PER_LAST = (ALERT_BLINKS == 0) ? 0 : ALERT_BLINKS - 1;

  typedef enum logic {
    NORMAL = 1'b0,
    ALERT  = 1'b1
  } state_t;

  state_t state, state_next;

  logic             sync1, btn_s;
  logic             deb, deb_d;
  logic [DEB_W-1:0] deb_cnt;
  logic [BLK_W-1:0] blink_cnt;
  logic [PER_W-1:0] period_cnt;
  logic             phase;
  logic             prof_latched;

  logic press, enter, wrap, period_last, timeout;

  // deb_d lets a press be a single-cycle event on the accepted rising level
  assign press       = deb & ~deb_d;
  assign enter       = (state == NORMAL) && press;
  assign wrap        = (blink_cnt == BLK_W'(BLINK_DIV - 1));
  assign period_last = (period_cnt == PER_W'(PER_LAST));
  assign timeout     = (ALERT_BLINKS != 0) && wrap && !phase && period_last;
  assign alert       = (state == ALERT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      btn_s   <= 1'b0;
      deb     <= 1'b0;
      deb_d   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= btnu;
      btn_s <= sync1;
      deb_d <= deb;
      if (btn_s == deb) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb     <= btn_s;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NORMAL;
    else        state <= state_next;
  end

  // A press and a timeout on the same edge both just leave ALERT
  always_comb begin
    state_next = state;
    case (state)
      NORMAL:  if (press) state_next = ALERT;
      ALERT:   if (press || timeout) state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
  end

  // The second wrap of each blink period is the one seen with phase low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt    <= '0;
      period_cnt   <= '0;
      phase        <= 1'b0;
      prof_latched <= 1'b0;
    end else if (enter) begin
      prof_latched <= prof;
      blink_cnt    <= '0;
      phase        <= 1'b1;
      period_cnt   <= '0;
    end else if (state == ALERT) begin
      if (wrap) begin
        blink_cnt <= '0;
        phase     <= ~phase;
        if (!phase) begin
          if (period_last) period_cnt <= '0;
          else             period_cnt <= period_cnt + PER_W'(1);
        end
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else if (state == ALERT) begin
      led <= prof_latched ? {LED_W{phase}} : '0;
    end else begin
      led <= {sw, hour, pm, prof, student};
    end
  end

endmodule

// File: tb/tb_led_status_panel.sv
// Directed bench for led_status_panel with short debounce/blink parameters;
// k in the loops counts posedges from the first edge that samples btnu high.
module tb_led_status_panel;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btnu = 1'b0;
  logic        student = 1'b0;
  logic        prof = 1'b0;
  logic        pm = 1'b0;
  logic [3:0]  hour = '0;
  logic [8:0]  sw = '0;
  logic [15:0] led;
  logic        alert;

  int numAsserts = 0;
  int numFailures = 0;

  always #5 clk = ~clk;

  led_status_panel #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_DIV(3),
    .ALERT_BLINKS(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btnu(btnu),
    .student(student),
    .prof(prof),
    .pm(pm),
    .hour(hour),
    .sw(sw),
    .led(led),
    .alert(alert)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [8:0] s, input logic [3:0] h,
                               input logic p, input logic pr, input logic st);
    sw      = s;
    hour    = h;
    pm      = p;
    prof    = pr;
    student = st;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] expLed, input logic expAlert);
    numAsserts++;
    assert (led === expLed) else begin
      numFailures++;
      $error("[TB] FAIL %s led: observed %h expected %h", tag, led, expLed);
    end
    numAsserts++;
    assert (alert === expAlert) else begin
      numFailures++;
      $error("[TB] FAIL %s alert: observed %b expected %b", tag, alert, expAlert);
    end
  endtask

  // Expected bar for an alert entered at k=6 that times out at k=18
  function automatic logic [15:0] blinkLed(int k, logic [15:0] packedVal);
    if (k <= 6 || k >= 19) return packedVal;
    return (((k - 7) / 3) % 2 == 0) ? 16'hFFFF : 16'h0000;
  endfunction

  initial begin
    $display("[TB] start");
    repeat (3) tick();
    checkOutput("reset_hold", 16'h0000, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // packed display
    @(negedge clk) applyStimulus(9'h1A5, 4'hC, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("pack_a", 16'hD2E5, 1'b0);
    @(negedge clk) student = 1'b0;
    tick();
    checkOutput("pack_b", 16'hD2E4, 1'b0);

    // short pulse and chatter are rejected
    @(negedge clk) btnu = 1'b1;
    repeat (3) tick();
    @(negedge clk) btnu = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) btnu = (i % 2 == 0);
    end
    @(negedge clk) btnu = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      checkOutput($sformatf("bounce_k%0d", k), 16'hD2E4, 1'b0);
    end

    // held press with prof set: blink then timeout, no retrigger
    @(negedge clk) prof = 1'b1;
    tick();
    checkOutput("pack_prof", 16'hD2E6, 1'b0);
    @(negedge clk) btnu = 1'b1;
    for (int k = 0; k < 26; k++) begin
      tick();
      checkOutput($sformatf("blink_k%0d", k), blinkLed(k, 16'hD2E6), (k >= 6 && k <= 17));
      if (k == 11) btnu = 1'b0;
    end
    repeat (10) tick();

    // prof clear at entry: dark bar, prof change ignored, second press exits
    @(negedge clk) prof = 1'b0;
    tick();
    checkOutput("pack_noprof", 16'hD2E4, 1'b0);
    @(negedge clk) btnu = 1'b1;
    for (int k = 0; k < 23; k++) begin
      logic [15:0] e;
      tick();
      e = (k <= 6) ? 16'hD2E4 : ((k <= 14) ? 16'h0000 : 16'hD2E6);
      checkOutput($sformatf("dark_k%0d", k), e, (k >= 6 && k <= 13));
      if (k == 3)  btnu = 1'b0;
      if (k == 7)  btnu = 1'b1;
      if (k == 9)  prof = 1'b1;
      if (k == 13) btnu = 1'b0;
    end
    repeat (10) tick();

    // second press accepted exactly on the timeout edge
    @(negedge clk) btnu = 1'b1;
    for (int k = 0; k < 31; k++) begin
      tick();
      checkOutput($sformatf("coincide_k%0d", k), blinkLed(k, 16'hD2E6), (k >= 6 && k <= 17));
      if (k == 3)  btnu = 1'b0;
      if (k == 11) btnu = 1'b1;
      if (k == 19) btnu = 1'b0;
    end
    repeat (10) tick();

    // asynchronous reset mid-cycle in NORMAL
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_normal", 16'h0000, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    checkOutput("rst_normal_rel", 16'hD2E6, 1'b0);

    // asynchronous reset mid-cycle in ALERT, then a fresh full-latency press
    @(negedge clk) btnu = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k == 8) checkOutput("pre_rst_alert", 16'hFFFF, 1'b1);
    end
    #2 rst_n = 1'b0;
    btnu = 1'b0;
    #1 checkOutput("rst_alert", 16'h0000, 1'b0);
    tick();
    checkOutput("rst_alert_hold", 16'h0000, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    checkOutput("rst_alert_rel", 16'hD2E6, 1'b0);
    @(negedge clk) btnu = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput($sformatf("repress_k%0d", k), blinkLed(k, 16'hD2E6), (k >= 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFailures);
    $finish;
  end

endmodule
